ball_motion_ctrl: RTL and testbench
===================================

// Module: ball_motion_ctrl
// PURPOSE
// Per-frame motion scheduler for the bouncing ball. On each vsync rising edge it sequences
// the X then Y position update with edge bounce, commits both coordinates atomically, and
// renders a ball-pixel flag from hpos/vpos. It replaces free-running per-line position
// counters and sits between video_sync_generator and the RGB mux in the *_sdl_top/board tops.
// PARAMETERS
// H_VISIBLE   640  visible width in pixels
// V_VISIBLE   480  visible height in lines
// BALL_SIZE   8    ball side length in pixels (square)
// INIT_X      128  X position after reset (left edge)
// INIT_Y      128  Y position after reset (top edge)
// INIT_DX     2    signed X step per frame after reset, |INIT_DX| < BALL_SIZE
// INIT_DY     2    signed Y step per frame after reset, |INIT_DY| < BALL_SIZE
// PORTS
// i_clk          in   1   pixel clock, all logic on rising edge
// i_rst          in   1   asynchronous, active-high reset
// i_vsync        in   1   vsync from video_sync_generator (active high)
// i_enable       in   1   1 = ball moves each frame; 0 = frozen
// i_hpos         in   10  current pixel column
// i_vpos         in   10  current pixel row
// i_visible      in   1   display active
// o_ball_x       out  10  committed ball left edge
// o_ball_y       out  10  committed ball top edge
// o_busy         out  1   1 while an update sequence is in progress
// o_bounce_x     out  1   1-cycle pulse at commit when X reflected
// o_bounce_y     out  1   1-cycle pulse at commit when Y reflected
// o_ball_gfx     out  1   registered: pixel (hpos,vpos) lies inside ball and visible
// BEHAVIOUR
// - Reset (async, i_rst=1): o_ball_x=INIT_X, o_ball_y=INIT_Y, dx=INIT_DX, dy=INIT_DY,
//   state=S_WAIT, vsync_q=0, o_busy=0, o_bounce_x/y=0, o_ball_gfx=0. Mid-sequence reset aborts it.
// - Edge detect: vsync_q<=i_vsync each cycle; start = i_vsync & ~vsync_q & i_enable in S_WAIT.
// - FSM: S_WAIT -start-> S_X -> S_Y -> S_COMMIT -> S_WAIT; one cycle per non-wait state.
//   S_X: nx = x+dx (11-bit signed). nx<0 -> nx=0, dx=-dx, bx=1.
//        nx>H_VISIBLE-BALL_SIZE -> nx=H_VISIBLE-BALL_SIZE, dx=-dx, bx=1.
//   S_Y: same rule on y/dy with V_VISIBLE, sets by.
//   S_COMMIT: o_ball_x<=nx, o_ball_y<=ny, o_bounce_x<=bx, o_bounce_y<=by (cleared next cycle).
// - Latency: edge sampled at cycle N (state leaves S_WAIT), outputs updated at N+3 edge.
// - o_busy=1 in S_X, S_Y, S_COMMIT. Vsync edges seen while busy are ignored (no queuing).
// - i_enable sampled only in S_WAIT; dropping it mid-sequence lets sequence finish.
// - Landing exactly on a bound (nx==0 or max) is not a bounce; reflect on overshoot only.
// - Both axes bouncing in the same frame: both pulses asserted in the same cycle.
// - dx or dy == 0: that axis never moves, never bounces.
// - o_ball_gfx <= i_visible & (hpos>=x) & (hpos<x+BALL_SIZE) & (vpos>=y) & (vpos<y+BALL_SIZE),
//   using committed x/y; 1-cycle latency vs i_hpos/i_vpos. Compare in 11 bits (no wrap).
// CONFIGURATION
// BALL_CTRL_STEP_EN defined: adds input i_step (1 bit). While i_enable=0, a 1-cycle i_step
//   pulse arms one update; the next vsync rising edge runs exactly one sequence, then disarms.
//   Arm flag resets to 0; i_step while i_enable=1 or while already armed has no effect.
// Not defined: no i_step port, no arm flag; i_enable=0 freezes the ball completely.
// TESTING
// 1 reset, i_enable=1, one vsync edge -> x=130,y=130 three cycles later, busy high 3 cycles.
// 2 preload x=634 (BALL_SIZE=8, dx=2) -> nx=636>632: x=632, dx=-2, o_bounce_x pulse once;
//   next frame x=630.
// 3 corner: x=1,y=1,dx=-2,dy=-2 -> x=0,y=0, both bounce pulses same cycle, next frame x=y=2.
// 4 i_enable=0 for 5 vsync edges -> x/y unchanged, busy never asserts; assert i_rst mid-S_Y
//   -> outputs INIT values immediately, state S_WAIT.
// 5 ball at (128,128): sweep hpos/vpos -> o_ball_gfx=1 exactly for 128..135 x 128..135,
//   one cycle after inputs, 0 when i_visible=0.
// 6 STEP_EN: i_enable=0, pulse i_step, 3 vsync edges -> exactly one move (x=130), then frozen.

Source files
------------

// File: rtl/ball_motion_ctrl.sv
// Per-frame bouncing-ball motion scheduler: X then Y update with edge reflection, atomic commit,
// registered ball-pixel flag. Optional single-step arming when BALL_CTRL_STEP_EN is defined.
module ball_motion_ctrl #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned BALL_SIZE = 8,
  parameter int unsigned INIT_X    = 128,
  parameter int unsigned INIT_Y    = 128,
  parameter int          INIT_DX   = 2,
  parameter int          INIT_DY   = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_vsync,
  input  logic       i_enable,
`ifdef BALL_CTRL_STEP_EN
  input  logic       i_step,
`endif
  input  logic [9:0] i_hpos,
  input  logic [9:0] i_vpos,
  input  logic       i_visible,
  output logic [9:0] o_ball_x,
  output logic [9:0] o_ball_y,
  output logic       o_busy,
  output logic       o_bounce_x,
  output logic       o_bounce_y,
  output logic       o_ball_gfx
);

  localparam logic signed [10:0] XMax = 11'(H_VISIBLE - BALL_SIZE);
  localparam logic signed [10:0] YMax = 11'(V_VISIBLE - BALL_SIZE);

  typedef enum logic [1:0] {StWait, StX, StY, StCommit} state_e;

  state_e state_q, state_d;
  logic vsync_q;
  logic [9:0] x_q, x_d, y_q, y_d, nx_q, nx_d, ny_q, ny_d;
  logic signed [10:0] dx_q, dx_d, dy_q, dy_d;
  logic bx_q, bx_d, by_q, by_d;
  logic bounce_x_q, bounce_x_d, bounce_y_q, bounce_y_d;
  logic gfx_q, gfx_d;
  logic go_en, start;
  logic signed [10:0] x_sum, y_sum;

`ifdef BALL_CTRL_STEP_EN
  logic armed_q, armed_d;
  assign go_en = i_enable | armed_q;

  // A start consumes the arm; a step only arms while the ball is frozen.
  always_comb begin
    armed_d = armed_q;
    if (start) begin
      armed_d = 1'b0;
    end else if (i_step && !i_enable) begin
      armed_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) armed_q <= 1'b0;
    else       armed_q <= armed_d;
  end
`else
  assign go_en = i_enable;
`endif

  assign start = (state_q == StWait) && i_vsync && !vsync_q && go_en;

  // FSM state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= StWait;
    else       state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StWait:   if (start) state_d = StX;
      StX:      state_d = StY;
      StY:      state_d = StCommit;
      StCommit: state_d = StWait;
      default:  state_d = StWait;
    endcase
  end

  // FSM outputs
  always_comb begin
    o_busy = (state_q != StWait);
  end

  assign x_sum = $signed({1'b0, x_q}) + dx_q;
  assign y_sum = $signed({1'b0, y_q}) + dy_q;

  // Reflect on overshoot only; landing exactly on a bound keeps the direction.
  always_comb begin
    nx_d       = nx_q;
    ny_d       = ny_q;
    dx_d       = dx_q;
    dy_d       = dy_q;
    bx_d       = bx_q;
    by_d       = by_q;
    x_d        = x_q;
    y_d        = y_q;
    bounce_x_d = 1'b0;
    bounce_y_d = 1'b0;
    unique case (state_q)
      StX: begin
        nx_d = x_sum[9:0];
        bx_d = 1'b0;
        if (x_sum < 0) begin
          nx_d = 10'd0;
          dx_d = -dx_q;
          bx_d = 1'b1;
        end else if (x_sum > XMax) begin
          nx_d = XMax[9:0];
          dx_d = -dx_q;
          bx_d = 1'b1;
        end
      end
      StY: begin
        ny_d = y_sum[9:0];
        by_d = 1'b0;
        if (y_sum < 0) begin
          ny_d = 10'd0;
          dy_d = -dy_q;
          by_d = 1'b1;
        end else if (y_sum > YMax) begin
          ny_d = YMax[9:0];
          dy_d = -dy_q;
          by_d = 1'b1;
        end
      end
      StCommit: begin
        x_d        = nx_q;
        y_d        = ny_q;
        bounce_x_d = bx_q;
        bounce_y_d = by_q;
      end
      default: ;
    endcase
  end

  // Widened to 11 bits so x + BALL_SIZE cannot wrap.
  always_comb begin
    gfx_d = i_visible
          && ({1'b0, i_hpos} >= {1'b0, x_q}) && ({1'b0, i_hpos} < {1'b0, x_q} + 11'(BALL_SIZE))
          && ({1'b0, i_vpos} >= {1'b0, y_q}) && ({1'b0, i_vpos} < {1'b0, y_q} + 11'(BALL_SIZE));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vsync_q    <= 1'b0;
      x_q        <= 10'(INIT_X);
      y_q        <= 10'(INIT_Y);
      nx_q       <= 10'(INIT_X);
      ny_q       <= 10'(INIT_Y);
      dx_q       <= 11'(INIT_DX);
      dy_q       <= 11'(INIT_DY);
      bx_q       <= 1'b0;
      by_q       <= 1'b0;
      bounce_x_q <= 1'b0;
      bounce_y_q <= 1'b0;
      gfx_q      <= 1'b0;
    end else begin
      vsync_q    <= i_vsync;
      x_q        <= x_d;
      y_q        <= y_d;
      nx_q       <= nx_d;
      ny_q       <= ny_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      bx_q       <= bx_d;
      by_q       <= by_d;
      bounce_x_q <= bounce_x_d;
      bounce_y_q <= bounce_y_d;
      gfx_q      <= gfx_d;
    end
  end

  assign o_ball_x   = x_q;
  assign o_ball_y   = y_q;
  assign o_bounce_x = bounce_x_q;
  assign o_bounce_y = bounce_y_q;
  assign o_ball_gfx = gfx_q;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Randomized bench for ball_motion_ctrl against a frame-level behavioural model, plus directed
// literal checks (first move, freeze, pixel sweep, mid-sequence reset, optional single step).
module tb_ball_motion_ctrl;

  localparam int HMax = 640 - 8;
  localparam int VMax = 480 - 8;

  logic       clk = 1'b0;
  logic       rst, vsync, en, visible;
  logic [9:0] hpos, vpos;
`ifdef BALL_CTRL_STEP_EN
  logic       step;
`endif
  logic [9:0] ball_x, ball_y;
  logic       busy, bounce_x, bounce_y, ball_gfx;

  int tests = 0;
  int fails = 0;

  ball_motion_ctrl dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_vsync    (vsync),
    .i_enable   (en),
`ifdef BALL_CTRL_STEP_EN
    .i_step     (step),
`endif
    .i_hpos     (hpos),
    .i_vpos     (vpos),
    .i_visible  (visible),
    .o_ball_x   (ball_x),
    .o_ball_y   (ball_y),
    .o_busy     (busy),
    .o_bounce_x (bounce_x),
    .o_bounce_y (bounce_y),
    .o_ball_gfx (ball_gfx)
  );

  always #5 clk = ~clk;

  // Frame-level model: a move is computed in one go when the edge is accepted,
  // then becomes visible three clocks later.
  int m_x, m_y, m_dx, m_dy, p_x, p_y, m_busy;
  bit m_vs, m_bx, m_by, p_bx, p_by, m_gfx, m_armed;

  task automatic move(input int pos, input int d, input int mx,
                      output int np, output int nd, output bit b);
    np = pos + d;
    nd = d;
    b  = 1'b0;
    if (np < 0) begin
      np = 0; nd = -d; b = 1'b1;
    end else if (np > mx) begin
      np = mx; nd = -d; b = 1'b1;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    bit go;
    if (rst) begin
      m_x = 128; m_y = 128; m_dx = 2; m_dy = 2; m_busy = 0;
      m_vs = 0; m_bx = 0; m_by = 0; m_gfx = 0; m_armed = 0;
    end else begin
      go    = 1'b0;
      m_gfx = visible && int'(hpos) >= m_x && int'(hpos) < m_x + 8
                      && int'(vpos) >= m_y && int'(vpos) < m_y + 8;
      m_bx  = 1'b0;
      m_by  = 1'b0;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_x = p_x; m_y = p_y; m_bx = p_bx; m_by = p_by;
        end
      end else if (vsync && !m_vs && (en || m_armed)) begin
        move(m_x, m_dx, HMax, p_x, m_dx, p_bx);
        move(m_y, m_dy, VMax, p_y, m_dy, p_by);
        m_busy = 3;
        go     = 1'b1;
      end
`ifdef BALL_CTRL_STEP_EN
      if (go) m_armed = 1'b0;
      else if (step && !en) m_armed = 1'b1;
`endif
      m_vs = vsync;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge and check every output against the model.
  task automatic tick();
    @(negedge clk);
    if (!rst) begin
      chk("x", int'(ball_x), m_x);
      chk("y", int'(ball_y), m_y);
      chk("busy", int'(busy), int'(m_busy != 0));
      chk("bounce_x", int'(bounce_x), int'(m_bx));
      chk("bounce_y", int'(bounce_y), int'(m_by));
      chk("gfx", int'(ball_gfx), int'(m_gfx));
    end
  endtask

  int max_x, min_x, max_y, min_y, nbx, nby;

  initial begin
    rst = 1'b1; vsync = 1'b0; en = 1'b0; visible = 1'b0; hpos = '0; vpos = '0;
`ifdef BALL_CTRL_STEP_EN
    step = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    chk("rst_x", int'(ball_x), 128);
    chk("rst_y", int'(ball_y), 128);
    chk("rst_busy", int'(busy), 0);
    chk("rst_gfx", int'(ball_gfx), 0);
    rst = 1'b0;
    tick();

    // First move: three busy cycles then (130,130).
    en = 1'b1;
    vsync = 1'b1;
    tick(); chk("t1_busy1", int'(busy), 1);
    vsync = 1'b0;
    tick(); chk("t1_busy2", int'(busy), 1);
    tick(); chk("t1_busy3", int'(busy), 1); chk("t1_hold_x", int'(ball_x), 128);
    tick(); chk("t1_busy_end", int'(busy), 0);
    chk("t1_x", int'(ball_x), 130);
    chk("t1_y", int'(ball_y), 130);

    // Frozen: five edges, nothing moves.
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      vsync = 1'b1;
      tick();
      vsync = 1'b0;
      for (int c = 0; c < 4; c++) begin
        tick();
        chk("t4_busy", int'(busy), 0);
      end
    end
    chk("t4_x", int'(ball_x), 130);
    chk("t4_y", int'(ball_y), 130);

    // Pixel sweep around the ball at (130,130).
    visible = 1'b1;
    for (int v = 126; v < 140; v++) begin
      for (int h = 126; h < 140; h++) begin
        hpos = 10'(h);
        vpos = 10'(v);
        tick();
        chk("t5_gfx", int'(ball_gfx), int'(h >= 130 && h <= 137 && v >= 130 && v <= 137));
      end
    end
    visible = 1'b0;
    hpos = 10'd132;
    vpos = 10'd132;
    tick();
    chk("t5_invisible", int'(ball_gfx), 0);

    // Random traffic, including edges that arrive while busy.
    max_x = 0; min_x = 1023; max_y = 0; min_y = 1023; nbx = 0; nby = 0;
    for (int f = 0; f < 1500; f++) begin
      int gap, high;
      gap  = int'($urandom_range(3, 12));
      high = int'($urandom_range(1, 2));
      en   = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < gap; c++) begin
        vsync   = (c < high);
        hpos    = 10'($urandom_range(0, 1023));
        vpos    = 10'($urandom_range(0, 1023));
        visible = $urandom_range(0, 1) != 0;
`ifdef BALL_CTRL_STEP_EN
        step    = ($urandom_range(0, 7) == 0);
`endif
        tick();
        if (int'(ball_x) > max_x) max_x = int'(ball_x);
        if (int'(ball_x) < min_x) min_x = int'(ball_x);
        if (int'(ball_y) > max_y) max_y = int'(ball_y);
        if (int'(ball_y) < min_y) min_y = int'(ball_y);
        nbx += int'(bounce_x);
        nby += int'(bounce_y);
      end
    end
`ifdef BALL_CTRL_STEP_EN
    step = 1'b0;
`endif
    chk("rand_max_x", max_x, HMax);
    chk("rand_min_x", min_x, 0);
    chk("rand_max_y", max_y, VMax);
    chk("rand_min_y", min_y, 0);
    chk("rand_saw_bx", int'(nbx > 0), 1);
    chk("rand_saw_by", int'(nby > 0), 1);

    // Reset while the sequence is in the Y step.
    en = 1'b1; vsync = 1'b0;
    tick(); tick();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_x", int'(ball_x), 128);
    chk("mid_rst_y", int'(ball_y), 128);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_bx", int'(bounce_x), 0);
    tick();
    rst = 1'b0;
    tick(); tick();
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_x", int'(ball_x), 128);

`ifdef BALL_CTRL_STEP_EN
    // One step pulse while frozen: exactly one move over three edges.
    en = 1'b0;
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      vsync = 1'b1;
      tick();
      vsync = 1'b0;
      for (int c = 0; c < 6; c++) tick();
    end
    chk("step_x", int'(ball_x), 130);
    chk("step_y", int'(ball_y), 130);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
